// File: rtl/lr_sc_arbiter.sv
// ============================================================================
// Module   : lr_sc_arbiter
// Purpose  : Round-robin arbiter for one shared memory port, sequencing LR/SC
//            atomics through an external reservation table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_sc_arbiter #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int N_IDS      = 2,
    localparam int IDW        = $clog2(N_IDS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_IDS-1:0]            i_req,
    input  logic [N_IDS-1:0]            i_we,
    input  logic [N_IDS-1:0]            i_lr,
    input  logic [N_IDS-1:0]            i_sc,
    input  logic [N_IDS*ADDR_WIDTH-1:0] i_addr,
    input  logic [N_IDS*DATA_WIDTH-1:0] i_wdata,
    output logic [N_IDS-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic [DATA_WIDTH-1:0]       o_mem_wdata,
    input  logic                        i_mem_ack,
    input  logic [DATA_WIDTH-1:0]       i_mem_rdata,
    output logic                        o_tbl_wr_en,
    output logic                        o_tbl_set_res,
    output logic                        o_tbl_check_res,
    output logic [IDW-1:0]              o_tbl_id,
    output logic [ADDR_WIDTH-1:0]       o_tbl_addr,
    input  logic                        i_tbl_gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MEM   = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_LR    = 2'd2,
        OP_SC    = 2'd3
    } op_t;

    state_t                  state, state_nxt;
    op_t                     op_q, gnt_op;
    logic [IDW-1:0]          last_grant, id_q, gnt_id, cand;
    logic                    any_req;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, resp_data;
    logic                    op_is_write;

    // Rotating priority: scan starts just past the most recent winner.
    always_comb begin
        any_req = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int i = 1; i <= N_IDS; i++) begin
            cand = IDW'((int'(last_grant) + i) % N_IDS);
            if (!any_req && i_req[cand]) begin
                any_req = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    always_comb begin
        gnt_op = OP_LOAD;
        if (i_sc[gnt_id])      gnt_op = OP_SC;
        else if (i_lr[gnt_id]) gnt_op = OP_LR;
        else if (i_we[gnt_id]) gnt_op = OP_STORE;
    end

    assign op_is_write = (op_q == OP_STORE) || (op_q == OP_SC);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = !any_req ? IDLE : ((gnt_op == OP_SC) ? CHECK : MEM);
            CHECK:   state_nxt = i_tbl_gnt ? MEM : RESP;
            MEM:     state_nxt = i_mem_ack ? RESP : MEM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_grant <= IDW'(N_IDS - 1);
            id_q       <= '0;
            op_q       <= OP_LOAD;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        id_q    <= gnt_id;
                        op_q    <= gnt_op;
                        addr_q  <= i_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= i_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                CHECK: begin
                    // A lost reservation completes with result 1 and no memory access.
                    if (!i_tbl_gnt) resp_data <= DATA_WIDTH'(1);
                end
                MEM: begin
                    if (i_mem_ack) resp_data <= op_is_write ? '0 : i_mem_rdata;
                end
                default: begin
                    last_grant <= id_q;
                end
            endcase
        end
    end

    always_comb begin
        o_ack           = '0;
        o_rdata         = '0;
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_mem_addr      = '0;
        o_mem_wdata     = '0;
        o_tbl_wr_en     = 1'b0;
        o_tbl_set_res   = 1'b0;
        o_tbl_check_res = 1'b0;
        o_tbl_id        = '0;
        o_tbl_addr      = '0;
        case (state)
            CHECK: begin
                o_tbl_check_res = 1'b1;
                o_tbl_id        = id_q;
                o_tbl_addr      = addr_q;
            end
            MEM: begin
                o_mem_req   = 1'b1;
                o_mem_we    = op_is_write;
                o_mem_addr  = addr_q;
                o_mem_wdata = wdata_q;
                if (i_mem_ack) begin
                    // Any write kills every hart's reservation on this address.
                    if (op_is_write) begin
                        o_tbl_wr_en = 1'b1;
                        o_tbl_addr  = addr_q;
                    end else if (op_q == OP_LR) begin
                        o_tbl_set_res = 1'b1;
                        o_tbl_id      = id_q;
                        o_tbl_addr    = addr_q;
                    end
                end
            end
            RESP: begin
                o_ack[id_q] = 1'b1;
                o_rdata     = resp_data;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lr_sc_arbiter.sv
// ============================================================================
// Module   : tb_lr_sc_arbiter
// Purpose  : Directed self-checking bench for lr_sc_arbiter (2 harts, 32-bit).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lr_sc_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, we = '0, lr = '0, sc = '0;
    logic [63:0] addr_bus = '0, wdata_bus = '0;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        tbl_wr_en, tbl_set_res, tbl_check_res;
    logic        tbl_id;
    logic [31:0] tbl_addr;
    logic        tbl_gnt = 1'b0;

    int errors = 0;
    int checks = 0;

    lr_sc_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_IDS(2)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_req(req), .i_we(we), .i_lr(lr), .i_sc(sc),
        .i_addr(addr_bus), .i_wdata(wdata_bus),
        .o_ack(ack), .o_rdata(rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_tbl_wr_en(tbl_wr_en), .o_tbl_set_res(tbl_set_res),
        .o_tbl_check_res(tbl_check_res), .o_tbl_id(tbl_id),
        .o_tbl_addr(tbl_addr), .i_tbl_gnt(tbl_gnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 LOAD, 1 STORE, 2 LR; zero-wait memory returning md.
    task automatic txn(input int h, input int kind, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] md);
        @(negedge clk);
        req[h] = 1'b1; we[h] = (kind == 1); lr[h] = (kind == 2);
        addr_bus[h*32 +: 32] = a; wdata_bus[h*32 +: 32] = wd;
        #1 chk("idle_ack", ack, 0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = md;
        #1;
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, kind == 1);
        chk("mem_addr", mem_addr, a);
        if (kind == 1) chk("mem_wdata", mem_wdata, wd);
        chk("tbl_wr_en", tbl_wr_en, kind == 1);
        chk("tbl_set_res", tbl_set_res, kind == 2);
        chk("tbl_check_res", tbl_check_res, 0);
        if (kind == 2) chk("tbl_id", tbl_id, h);
        if (kind != 0) chk("tbl_addr", tbl_addr, a);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("resp_ack", ack, 2'b01 << h);
        chk("resp_rdata", rdata, (kind == 1) ? 32'h0 : md);
        chk("resp_mem_req", mem_req, 0);
        req[h] = 1'b0; we[h] = 1'b0; lr[h] = 1'b0;
    endtask

    task automatic sc_txn(input int h, input logic [31:0] a,
                          input logic [31:0] wd, input logic g);
        @(negedge clk);
        req[h] = 1'b1; sc[h] = 1'b1;
        addr_bus[h*32 +: 32] = a; wdata_bus[h*32 +: 32] = wd;
        #1 chk("sc_idle_check", tbl_check_res, 0);
        @(negedge clk);
        tbl_gnt = g;
        #1;
        chk("sc_check_res", tbl_check_res, 1);
        chk("sc_tbl_id", tbl_id, h);
        chk("sc_tbl_addr", tbl_addr, a);
        chk("sc_check_mem_req", mem_req, 0);
        chk("sc_check_wr_en", tbl_wr_en, 0);
        @(negedge clk);
        tbl_gnt = 1'b0;
        if (g) begin
            mem_ack = 1'b1;
            #1;
            chk("sc_mem_req", mem_req, 1);
            chk("sc_mem_we", mem_we, 1);
            chk("sc_mem_addr", mem_addr, a);
            chk("sc_mem_wdata", mem_wdata, wd);
            chk("sc_wr_en", tbl_wr_en, 1);
            chk("sc_wr_addr", tbl_addr, a);
            chk("sc_mem_check_res", tbl_check_res, 0);
            @(negedge clk);
            mem_ack = 1'b0;
        end
        #1;
        chk("sc_ack", ack, 2'b01 << h);
        chk("sc_rdata", rdata, g ? 32'd0 : 32'd1);
        chk("sc_resp_mem_req", mem_req, 0);
        chk("sc_resp_check_res", tbl_check_res, 0);
        req[h] = 1'b0; sc[h] = 1'b0;
    endtask

    initial begin
        // Reset: requests present but nothing may start.
        req = 2'b01;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_tbl", {tbl_wr_en, tbl_set_res, tbl_check_res}, 0);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Both harts held: grants alternate starting with hart 0.
        @(negedge clk);
        req = 2'b11;
        addr_bus = {32'h20, 32'h10};
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_idle_ack", ack, 0);
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = 32'hA0 + k;
            #1 chk("rr_mem_addr", mem_addr, (k % 2) ? 32'h20 : 32'h10);
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            chk("rr_ack", ack, (k % 2) ? 2'b10 : 2'b01);
            chk("rr_rdata", rdata, 32'hA0 + k);
            @(negedge clk);
        end
        req = 2'b00;

        txn(0, 0, 32'h100, 32'h0, 32'hDEAD);
        // LR then successful SC.
        txn(0, 2, 32'h200, 32'h0, 32'h77);
        sc_txn(0, 32'h200, 32'd5, 1'b1);
        // LR, intervening store by hart 1, failed SC.
        txn(0, 2, 32'h200, 32'h0, 32'h78);
        txn(1, 1, 32'h200, 32'h1234, 32'h0);
        sc_txn(0, 32'h200, 32'd6, 1'b0);
        // SC with no reservation.
        sc_txn(1, 32'h300, 32'd9, 1'b0);

        // Two memory wait states: request and operands stay stable.
        @(negedge clk);
        req[1] = 1'b1; addr_bus[63:32] = 32'h400;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            mem_ack = (w == 2); mem_rdata = 32'hBEEF;
            #1;
            chk("wait_mem_req", mem_req, 1);
            chk("wait_mem_addr", mem_addr, 32'h400);
            chk("wait_ack", ack, 0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("wait_resp_ack", ack, 2'b10);
        chk("wait_resp_rdata", rdata, 32'hBEEF);
        req = 2'b00;

        // Reset in the middle of a store.
        @(negedge clk);
        req = 2'b01; we = 2'b01; addr_bus = {32'h600, 32'h500}; wdata_bus[31:0] = 32'h55;
        @(negedge clk);
        #1 chk("abort_mem_req_before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_ack", ack, 0);
        @(negedge clk);
        #1 chk("abort_ack_later", ack, 0);
        we = 2'b00; req = 2'b11;
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h99;
        #1;
        chk("post_rst_addr", mem_addr, 32'h500);
        chk("post_rst_we", mem_we, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("post_rst_ack", ack, 2'b01);
        req = 2'b00;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
